// File: rtl/wb_display_pkg.sv
// Shared types and constants for the Wishbone display image writer.
// Optional read-back verify is enabled by defining WB_DISPLAY_WRITER_VERIFY_EN.
package wb_display_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StGap,
    StRd,
    StRdGap,
    StDone
  } state_e;

  localparam int unsigned NUM_DIGITS      = 8;
  localparam int unsigned POINT_IDX       = 8;
  localparam int unsigned REG_STRIDE      = 4;
  localparam logic [7:0]  DEFAULT_TIMEOUT = 8'd255;

  // Register k < NUM_DIGITS carries BCD digit k; register POINT_IDX carries the point mask.
  function automatic logic [31:0] xfer_data(input logic [31:0] value, input logic [7:0] point,
                                            input logic [3:0] idx);
    if (idx == 4'(POINT_IDX)) begin
      return {24'd0, point};
    end
    return {28'd0, value[{idx[2:0], 2'b00} +: 4]};
  endfunction

endpackage

// File: rtl/wb_display_writer_if.sv
// Wishbone classic bus between the display writer (master) and the display register file.
// Used unchanged whether or not WB_DISPLAY_WRITER_VERIFY_EN is defined.
interface wb_display_writer_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;

  modport master (output adr, dat_w, sel, cyc, stb, we, input dat_r, ack);
  modport slave (input adr, dat_w, sel, cyc, stb, we, output dat_r, ack);
endinterface

// File: rtl/wb_display_writer.sv
// Pushes 8 BCD digits plus the point mask into the display register file as 9 single writes.
// Define WB_DISPLAY_WRITER_VERIFY_EN to read back and compare each register after writing it.
module wb_display_writer
  import wb_display_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                value,
  input  logic [7:0]                 point,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  wb_display_writer_if.master        wb
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  point_q, point_d;
  logic        err_q, err_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;

  logic timeout_hit;
  logic last_xfer;
  logic rd_match;

  assign timeout_hit = (TIMEOUT != 8'd0) && (cnt_q == TIMEOUT);
  assign last_xfer   = (idx_q == 4'(POINT_IDX));

`ifdef WB_DISPLAY_WRITER_VERIFY_EN
  assign rd_match = last_xfer ? (wb.dat_r[7:0] == point_q) : (wb.dat_r[3:0] == dat_q[3:0]);
`else
  logic unused_dat_r;
  assign unused_dat_r = ^wb.dat_r;
  assign rd_match     = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      value_q <= 32'd0;
      point_q <= 8'd0;
      err_q   <= 1'b0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      point_q <= point_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  // An ack coinciding with the timeout limit wins: it is checked first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StReq;
      StReq: begin
        if (wb.ack) begin
          state_d = StGap;
        end else if (timeout_hit) begin
          state_d = StDone;
        end
      end
      StGap: begin
`ifdef WB_DISPLAY_WRITER_VERIFY_EN
        state_d = StRd;
`else
        state_d = last_xfer ? StDone : StReq;
`endif
      end
      StRd: begin
        if (wb.ack) begin
          state_d = rd_match ? StRdGap : StDone;
        end else if (timeout_hit) begin
          state_d = StDone;
        end
      end
      StRdGap: state_d = last_xfer ? StDone : StReq;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    point_d = point_q;
    err_d   = err_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          value_d = value;
          point_d = point;
          err_d   = 1'b0;
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          adr_d   = BASE_ADR;
          dat_d   = xfer_data(value, point, 4'd0);
        end
      end
      StReq: begin
        cnt_d = cnt_q + 8'd1;
        if (!wb.ack && timeout_hit) err_d = 1'b1;
      end
      StRd: begin
        cnt_d = cnt_q + 8'd1;
        if (wb.ack && !rd_match) begin
          err_d = 1'b1;
        end else if (!wb.ack && timeout_hit) begin
          err_d = 1'b1;
        end
      end
      StGap: begin
        cnt_d = 8'd0;
`ifndef WB_DISPLAY_WRITER_VERIFY_EN
        if (!last_xfer) begin
          idx_d = idx_q + 4'd1;
          adr_d = adr_q + REG_STRIDE;
          dat_d = xfer_data(value_q, point_q, idx_q + 4'd1);
        end
`endif
      end
      StRdGap: begin
        cnt_d = 8'd0;
        if (!last_xfer) begin
          idx_d = idx_q + 4'd1;
          adr_d = adr_q + REG_STRIDE;
          dat_d = xfer_data(value_q, point_q, idx_q + 4'd1);
        end
      end
      default: ;
    endcase
  end

  // Bus strobes are decoded from the registered state so reset drops them at once.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    err      = err_q;
    wb.cyc   = (state_q == StReq) || (state_q == StRd);
    wb.stb   = (state_q == StReq) || (state_q == StRd);
    wb.we    = (state_q == StReq);
    wb.adr   = adr_q;
    wb.dat_w = dat_q;
    wb.sel   = 4'b1111;
  end

endmodule

// File: tb/tb_wb_display_writer.sv
// Directed bench for wb_display_writer with a registered-ack display responder model.
// Covers the read-back verify abort when WB_DISPLAY_WRITER_VERIFY_EN is defined.
module tb_wb_display_writer;
  import wb_display_pkg::*;

  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam logic [25:0] BASE_HI = BASE[31:6];
  localparam logic [7:0]  TMO     = 8'd10;
`ifdef WB_DISPLAY_WRITER_VERIFY_EN
  localparam int P = 6;
`else
  localparam int P = 3;
`endif

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic [7:0]  point;
  logic        busy, done, err;

  wb_display_writer_if wb();

  wb_display_writer #(
    .BASE_ADR(BASE),
    .TIMEOUT (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .value(value),
    .point(point),
    .busy (busy),
    .done (done),
    .err  (err),
    .wb   (wb)
  );

  always #5 clk = ~clk;

  // Responder: ack registered from stb, so it lingers one cycle after stb drops.
  int          no_ack_idx  = -1;
  int          corrupt_idx = -1;
  logic [3:0]  acc_idx;
  logic        in_range;
  logic        ack_q;
  logic [31:0] regs [0:8];

  always_comb begin
    acc_idx  = wb.adr[5:2];
    in_range = (wb.adr[31:6] == BASE_HI) && (acc_idx <= 4'd8);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) ack_q <= 1'b0;
    else       ack_q <= wb.cyc && wb.stb && !(int'(acc_idx) == no_ack_idx);
  end

  always @(posedge clk) begin
    if (wb.cyc && wb.stb && wb.we && wb.ack && in_range) regs[acc_idx] <= wb.dat_w;
  end

  assign wb.ack   = ack_q;
  assign wb.dat_r = (in_range && int'(acc_idx) == corrupt_idx) ? 32'h0000_000F :
                    (in_range ? regs[acc_idx] : 32'h0);

  // Monitor: logs completed transfers, done pulses, strobe run lengths and idle gaps.
  int          cyc_n   = 0;
  int          stb_run = 0;
  int          low_run = 0;
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  int          done_q[$];
  int          stb_q[$];
  int          gap_q[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (wb.cyc && wb.stb && wb.ack) begin
      if (wb.we) wr_q.push_back(wr_t'{adr: wb.adr, dat: wb.dat_w, cyc: cyc_n});
      else       rd_q.push_back(wb.adr);
    end
    if (done) done_q.push_back(cyc_n);
    if (wb.stb) begin
      stb_run <= stb_run + 1;
    end else if (stb_run != 0) begin
      stb_q.push_back(stb_run);
      stb_run <= 0;
    end
    if (busy && !wb.cyc) begin
      low_run <= low_run + 1;
    end else begin
      if (wb.cyc && low_run != 0) gap_q.push_back(low_run);
      low_run <= 0;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Caller is at a negedge; start is sampled on the following posedge (cycle 0).
  task automatic pulse_start(input logic [31:0] v, input logic [7:0] p);
    value = v;
    point = p;
    start = 1'b1;
    t0    = cyc_n;
    @(negedge clk);
    start = 1'b0;
    value = ~v;
    point = ~p;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic verify_burst(input string tag, input logic [31:0] v, input logic [7:0] p,
                              input int bw, input int t);
    logic [31:0] exp_dat;
    check({tag, "_nwr"}, 32'(wr_q.size() - bw), 32'd9);
    for (int k = 0; k < 9; k++) begin
      if (bw + k < wr_q.size()) begin
        exp_dat = (k < 8) ? {28'd0, v[4*k +: 4]} : {24'd0, p};
        check($sformatf("%s_adr%0d", tag, k), wr_q[bw+k].adr, BASE + 32'(4 * k));
        check($sformatf("%s_dat%0d", tag, k), wr_q[bw+k].dat, exp_dat);
        check($sformatf("%s_cyc%0d", tag, k), 32'(wr_q[bw+k].cyc - t), 32'(2 + P * k));
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bw, bd, bg, br, t4;
    reset = 1'b1;
    start = 1'b0;
    value = 32'd0;
    point = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cyc", 32'(wb.cyc), 32'd0);
    check("rst_stb", 32'(wb.stb), 32'd0);
    check("rst_we", 32'(wb.we), 32'd0);
    check("rst_adr", wb.adr, 32'd0);
    check("rst_dat", wb.dat_w, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full image, 1-wait responder.
    bw = wr_q.size(); bd = done_q.size(); bg = gap_q.size();
    pulse_start(32'h8765_4321, 8'hFE);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1");
    check("t1_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    check("t1_idle", 32'(busy), 32'd0);
    verify_burst("t1", 32'h8765_4321, 8'hFE, bw, t0);
    check("t1_ndone", 32'(done_q.size() - bd), 32'd1);
    if (done_q.size() > bd) check("t1_done_cyc", 32'(done_q[bd] - t0), 32'(9 * P + 1));
    check("t1_ngap", 32'(gap_q.size() - bg), 32'(9 * (P / 3) - 1));
    for (int i = bg; i < gap_q.size(); i++) check("t1_gap_len", 32'(gap_q[i]), 32'd1);

    // Transfer 3 never acked: timeout abort.
    no_ack_idx = 3;
    bw = wr_q.size(); bd = done_q.size();
    pulse_start(32'h1357_9024, 8'h7F);
    wait_done("t2");
    check("t2_err", 32'(err), 32'd1);
    check("t2_cyc_low", 32'(wb.cyc), 32'd0);
    repeat (4) @(negedge clk);
    check("t2_nwr", 32'(wr_q.size() - bw), 32'd3);
    check("t2_ndone", 32'(done_q.size() - bd), 32'd1);
    check("t2_stb_run", 32'(stb_q[$]), 32'(TMO) + 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    no_ack_idx = -1;
    bw = wr_q.size();
    pulse_start(32'h0246_8135, 8'hBF);
    check("t2_err_clr", 32'(err), 32'd0);
    wait_done("t2b");
    check("t2b_err", 32'(err), 32'd0);
    @(negedge clk);
    verify_burst("t2b", 32'h0246_8135, 8'hBF, bw, t0);

    // Second start during the burst is ignored.
    @(negedge clk);
    bw = wr_q.size(); bd = done_q.size();
    pulse_start(32'h2468_1357, 8'hF0);
    repeat (4) @(negedge clk);
    value = 32'h9999_9999;
    point = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3");
    repeat (2) @(negedge clk);
    verify_burst("t3", 32'h2468_1357, 8'hF0, bw, t0);
    check("t3_ndone", 32'(done_q.size() - bd), 32'd1);
    if (done_q.size() > bd) check("t3_done_cyc", 32'(done_q[bd] - t0), 32'(9 * P + 1));

    // Asynchronous reset during transfer index 3.
    bd = done_q.size();
    pulse_start(32'h8765_4321, 8'hFE);
    repeat (3 * P) @(negedge clk);
    check("t4_pre_cyc", 32'(wb.cyc), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t4_cyc", 32'(wb.cyc), 32'd0);
    check("t4_stb", 32'(wb.stb), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_no_done", 32'(done_q.size() - bd), 32'd0);
    bw = wr_q.size();
    pulse_start(32'h1111_2222, 8'h55);
    t4 = t0;
    wait_done("t4");

    // Back-to-back: start in the cycle right after done.
    @(negedge clk);
    br = wr_q.size();
    pulse_start(32'h3141_5926, 8'hAA);
    check("t6_busy", 32'(busy), 32'd1);
    verify_burst("t4", 32'h1111_2222, 8'h55, bw, t4);
    bd = done_q.size();
    wait_done("t6");
    repeat (2) @(negedge clk);
    verify_burst("t6", 32'h3141_5926, 8'hAA, br, t0);
    check("t6_ndone", 32'(done_q.size() - bd), 32'd1);

`ifdef WB_DISPLAY_WRITER_VERIFY_EN
    // Read-back of digit 5 corrupted: abort after reading BASE+0x10.
    corrupt_idx = 4;
    bw = wr_q.size(); bd = done_q.size(); br = rd_q.size();
    pulse_start(32'h8765_4321, 8'hFE);
    wait_done("t5");
    check("t5_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_nwr", 32'(wr_q.size() - bw), 32'd5);
    check("t5_nrd", 32'(rd_q.size() - br), 32'd5);
    check("t5_last_rd", rd_q[$], BASE + 32'h10);
    check("t5_ndone", 32'(done_q.size() - bd), 32'd1);
    corrupt_idx = -1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_display_writer.md
Name: wb_display_writer

Overview:
Wishbone classic initiator that pushes a full display image (8 BCD digits plus decimal-point mask) into the 7-segment display peripheral's register file.
- A local start/value/point request interface launches a burst of 9 single write cycles.
- Ack wait, a per-transfer timeout and inter-transfer spacing are handled so the display peripheral's registered-ack responder is never double-acked.
- Sits between the LM32-side control logic (or a hardware counter) and the display slave on the SoC bus.

Parameters:
- BASE_ADR, 32'h0000_0000, byte address of the display register 0 (digit 1).
- TIMEOUT, 8'd255, max cycles waiting for wb_ack_i per transfer before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- value  in  32  8 BCD nibbles; digit k (k=0..7) = value[4k+3:4k]
- point  in  8  decimal-point mask (active-low, as the display expects)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of sequence (success or abort)
- err  out  1  set on timeout (or verify mismatch); cleared by the next accepted start
- wb_adr_o  out  32  BASE_ADR + 4*k, k = 0..8
- wb_dat_o  out  32  {28'd0, nibble} for k<8; {24'd0, point} for k=8
- wb_sel_o  out  4  constant 4'b1111
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_ack_i  in  1  responder ack
- wb_dat_i  in  32  read data (used only with verify feature)

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, err=0, cyc=stb=we=0, adr=0, dat=0, index=0, timeout count=0. Reset mid-burst drops cyc/stb immediately; no partial completion pulse.
- IDLE: start=1 latches value/point, clears err, index=0, goes to REQ. start while busy is ignored, not queued.
- REQ: cyc=stb=we=1; adr/dat per index; counter increments each cycle.
  - ack=1: goes to GAP with cyc=stb=0 registered, so the bus is low the next cycle.
  - counter==TIMEOUT (TIMEOUT != 0) with no ack: drops cyc/stb, sets err, goes to DONE.
- GAP: exactly one cycle with cyc=stb=0. This is required because the display responder holds its registered ack high one cycle after stb drops. Then: index==8 -> DONE; else index+1 -> REQ, counter=0.
- DONE: done=1 for one cycle, busy=0 next cycle, returns to IDLE. The next start can be accepted in the cycle after DONE.
- Timing with a 1-wait-state responder: start at cycle 0; stb cycles 1-2; first ack at cycle 2. Each transfer takes 3 cycles, so the last ack is at cycle 26 and done pulses at cycle 28.
- ack in GAP, IDLE or DONE is ignored. An ack in the same cycle the timeout reaches its limit is treated as success.
- Index is 4 bits and never exceeds 8; addresses do not wrap.

Optional Feature:
Macro WB_DISPLAY_WRITER_VERIFY_EN.
- Defined: after each write's GAP, issue a read (we=0) to the same address, followed by one more GAP cycle.
  - Compare wb_dat_i[3:0] against the written nibble (k<8), or wb_dat_i[7:0] against point (k=8).
  - Mismatch sets err and aborts to DONE.
  - The read also obeys TIMEOUT.
  - Adds states RD and RD_GAP; burst length becomes 6 cycles/transfer.
- Not defined: write-only; wb_dat_i unused; err means timeout only.

Decomposition:
Package wb_display_pkg holds:
- State encoding: IDLE, REQ, GAP, RD, RD_GAP, DONE.
- NUM_DIGITS=8, POINT_IDX=8, REG_STRIDE=4.
- Default TIMEOUT.

Single module; the timeout counter and data mux are inline. No sub-module needed.

Test Plan:
1. value=32'h8765_4321, point=8'hFE, 1-wait responder model: writes of 1,2,...,8 to BASE+0..BASE+0x1C, then 0xFE to BASE+0x20; cyc low for exactly 1 cycle between transfers; done pulses once at cycle 28; err=0.
2. Responder never acks transfer 3, TIMEOUT=10: stb held 11 cycles, then cyc/stb drop, err=1, done pulse, no further writes; next start clears err.
3. start pulsed again at cycle 5 of a burst with a different value: ignored; burst completes with the original latched data.
4. reset asserted mid-REQ at transfer 4: cyc/stb/busy go to 0 asynchronously (same timestep); done never pulses; fresh start after release restarts at index 0.
5. VERIFY_EN defined, responder corrupts read data of digit 5 (returns 4'hF, written 4'h5): err=1, abort after the read of BASE+0x10, done pulse.
6. Back-to-back starts: start asserted the cycle after done; second burst begins immediately and completes with correct addresses.
